// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter feeding single SPI master from two LCD requesters
//
// Purpose
//    Accepts transfer requests from two requesters (0: LCD command path,
//    1: LCD pixel path), picks one round-robin, captures its word and
//    data/command flag, launches the SPI master with a one-cycle start
//    pulse and waits for completion or a timeout before accepting the
//    next request.
//
// Parameters
//    DATA_W   width of one SPI transfer word
//    TIMEOUT  maximum WAIT cycles before a transfer is aborted (1..65535)
//
// Ports
//    clk          system clock, rising edge
//    rst          asynchronous active-high reset
//    req0/req1    transfer request, held until granted
//    data0/data1  word offered by each requester
//    dc0/dc1      data/command flag offered by each requester
//    grant0/1     one-cycle pulse: the offered word has been captured
//    spi_start    one-cycle pulse launching the SPI master
//    spi_data     captured word, stable until the next grant
//    spi_dc       captured data/command flag, stable until the next grant
//    spi_done     single-cycle completion pulse from the SPI master
//    busy         high while a transfer is outstanding
//    timeout_err  one-cycle pulse when a transfer is aborted

module spi_txn_arbiter #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic              dc0,
   input  logic              dc1,
   output logic              grant0,
   output logic              grant1,
   output logic              spi_start,
   output logic [DATA_W-1:0] spi_data,
   output logic              spi_dc,
   input  logic              spi_done,
   output logic              busy,
   output logic              timeout_err
);

   // Counter only ever counts up to TIMEOUT, so this width never wraps.
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              last_q, last_d;     // requester served most recently
   logic              grant0_d, grant1_d;
   logic              start_d;
   logic              busy_d;
   logic              terr_d;
   logic [DATA_W-1:0] data_d;
   logic              dc_d;
   logic              pick1;

   // Requester 1 wins when it is alone, or on a tie when requester 0 was
   // served last.
   assign pick1   = req1 && (!req0 || !last_q);
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      start_d  = 1'b0;
      busy_d   = busy;
      terr_d   = 1'b0;
      data_d   = spi_data;
      dc_d     = spi_dc;

      unique case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (req0 || req1) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
               busy_d  = 1'b1;
               start_d = 1'b1;
               last_d  = pick1;
               if (pick1) begin
                  grant1_d = 1'b1;
                  data_d   = data1;
                  dc_d     = dc1;
               end else begin
                  grant0_d = 1'b1;
                  data_d   = data0;
                  dc_d     = dc0;
               end
            end
         end

         ST_WAIT: begin
            // Completion is checked first so that a done on the same edge
            // as the timeout wins and no error is flagged.
            if (spi_done) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (cnt_inc == CNT_LIMIT) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               terr_d  = 1'b1;
               cnt_d   = cnt_inc;
            end else begin
               cnt_d   = cnt_inc;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b1;   // requester 0 wins the first tie
         grant0      <= 1'b0;
         grant1      <= 1'b0;
         spi_start   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         spi_data    <= '0;
         spi_dc      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         grant0      <= grant0_d;
         grant1      <= grant1_d;
         spi_start   <= start_d;
         busy        <= busy_d;
         timeout_err <= terr_d;
         spi_data    <= data_d;
         spi_dc      <= dc_d;
      end
   end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - directed self-checking bench for spi_txn_arbiter

module tb_spi_txn_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       dc0 = 1'b0, dc1 = 1'b0;
   logic       grant0, grant1, spi_start, spi_dc, busy, timeout_err;
   logic [7:0] spi_data;
   logic       spi_done = 1'b0;

   int n_checks = 0;
   int n_fails  = 0;

   spi_txn_arbiter #(.DATA_W(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .data0(data0), .data1(data1),
      .dc0(dc0), .dc1(dc1),
      .grant0(grant0), .grant1(grant1),
      .spi_start(spi_start), .spi_data(spi_data), .spi_dc(spi_dc),
      .spi_done(spi_done), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // {grant0, grant1, spi_start, busy, timeout_err}
   function automatic logic [31:0] ctl();
      return 32'({grant0, grant1, spi_start, busy, timeout_err});
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      tick();
      chk("rst_hold_ctl", ctl(), 32'h00);
      tick();
      rst = 1'b0;
      chk("rst_ctl", ctl(), 32'h00);
      chk("rst_data", 32'({spi_dc, spi_data}), 32'h000);

      // ---------------- fairness: both held, alternate 0,1,0,1 ----------------
      req0 = 1'b1; data0 = 8'h11; dc0 = 1'b1;
      req1 = 1'b1; data1 = 8'h22; dc1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k % 2 == 0) begin
            chk("fair_grant0", ctl(), 32'b10110);
            chk("fair_data0", 32'({spi_dc, spi_data}), 32'h111);
         end else begin
            chk("fair_grant1", ctl(), 32'b01110);
            chk("fair_data1", 32'({spi_dc, spi_data}), 32'h022);
         end
         spi_done = 1'b1;
         tick();
         spi_done = 1'b0;
         chk("fair_idle", ctl(), 32'b00000);
      end
      req0 = 1'b0; req1 = 1'b0;

      // ---------------- single request ----------------
      req0 = 1'b1; data0 = 8'hA5; dc0 = 1'b0;
      tick();
      req0 = 1'b0;
      chk("single_grant", ctl(), 32'b10110);
      chk("single_data", 32'({spi_dc, spi_data}), 32'h0A5);
      tick();
      chk("single_wait1", ctl(), 32'b00010);
      tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk("single_done", ctl(), 32'b00000);
      chk("single_hold", 32'({spi_dc, spi_data}), 32'h0A5);

      // ---------------- timeout (TIMEOUT = 4) ----------------
      req1 = 1'b1; data1 = 8'h3C; dc1 = 1'b1;
      tick();
      req1 = 1'b0;
      chk("to_grant1", ctl(), 32'b01110);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("to_waiting", ctl(), 32'b00010);
      end
      tick();
      chk("to_pulse", ctl(), 32'b00001);
      chk("to_data", 32'({spi_dc, spi_data}), 32'h13C);
      tick();
      chk("to_pulse_end", ctl(), 32'b00000);

      // next request is accepted after the abort
      req0 = 1'b1; data0 = 8'h5A; dc0 = 1'b0;
      tick();
      req0 = 1'b0;
      chk("to_next_grant", ctl(), 32'b10110);

      // ---------------- done on the same edge as timeout ----------------
      tick();
      tick();
      tick();
      chk("sim_waiting", ctl(), 32'b00010);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk("sim_no_err", ctl(), 32'b00000);
      tick();
      chk("sim_no_err_after", ctl(), 32'b00000);

      // ---------------- request dropped while busy + stray done ----------------
      req0 = 1'b1; data0 = 8'h77; dc0 = 1'b1;
      tick();
      req0 = 1'b0;
      chk("drop_grant0", ctl(), 32'b10110);
      req1 = 1'b1; data1 = 8'hEE; dc1 = 1'b0;
      tick();
      req1 = 1'b0;
      chk("drop_wait", ctl(), 32'b00010);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk("drop_done", ctl(), 32'b00000);
      tick();
      chk("drop_no_grant1", ctl(), 32'b00000);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk("stray_done", ctl(), 32'b00000);
      tick();
      chk("stray_after", ctl(), 32'b00000);
      chk("stray_data", 32'({spi_dc, spi_data}), 32'h177);

      // ---------------- reset mid-WAIT ----------------
      req0 = 1'b1; data0 = 8'h99; dc0 = 1'b1;
      tick();
      req0 = 1'b0;
      chk("rw_grant0", ctl(), 32'b10110);
      #2;
      rst = 1'b1;
      #1;
      chk("rw_async_ctl", ctl(), 32'b00000);
      chk("rw_async_data", 32'({spi_dc, spi_data}), 32'h000);
      tick();
      rst = 1'b0;
      chk("rw_release", ctl(), 32'b00000);
      req0 = 1'b1; data0 = 8'hAA; dc0 = 1'b0;
      req1 = 1'b1; data1 = 8'hBB; dc1 = 1'b1;
      tick();
      req0 = 1'b0; req1 = 1'b0;
      chk("rw_tie_grant0", ctl(), 32'b10110);
      chk("rw_tie_data", 32'({spi_dc, spi_data}), 32'h0AA);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk("rw_end", ctl(), 32'b00000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one SPI transfer word.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before abort; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: fast system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports req0 / req1, input, 1: transfer request from requester 0 (LCD command path) / requester 1 (LCD pixel path).
REQ-006 SHALL have ports data0 / data1, input, DATA_W: word offered by each requester.
REQ-007 SHALL have ports dc0 / dc1, input, 1: LCD data/command flag offered by each requester.
REQ-008 SHALL have ports grant0 / grant1, output, 1: one-cycle pulse; the offered word has been captured.
REQ-009 SHALL have port spi_start, output, 1: one-cycle pulse that launches the SPI master.
REQ-010 SHALL have port spi_data, output, DATA_W: captured word, stable from spi_start until the next grant.
REQ-011 SHALL have port spi_dc, output, 1: captured dc flag, same stability as spi_data.
REQ-012 SHALL have port spi_done, input, 1: single-cycle completion pulse, already synchronized into clk.
REQ-013 SHALL have port busy, output, 1: high while a transfer is outstanding.
REQ-014 SHALL have port timeout_err, output, 1: one-cycle pulse when a transfer is aborted.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-016 SHALL, in IDLE with at least one req high at a clock edge, move to WAIT at that edge.
- At the same edge: capture the winner's data/dc into spi_data/spi_dc; pulse the winner's grant for exactly one cycle; pulse spi_start for exactly one cycle; set busy.
- Latency: grant, spi_start and busy are high in the cycle after the sampling edge.
REQ-017 SHALL arbitrate round-robin; when only one req is high, that requester wins.
- Both high: the winner is the requester not served last.
- The last-served pointer updates only on a grant.
REQ-018 SHALL assert at most one grant in any cycle; every grant SHALL coincide with spi_start.
REQ-019 SHALL ignore req0/req1 while in WAIT; requesters hold req, data and dc stable until their grant. A req dropped before its grant is never served.
REQ-020 SHALL run a WAIT cycle counter, cleared on entry to WAIT.
REQ-021 SHALL, on spi_done high in WAIT, return to IDLE at that edge and clear busy.
REQ-022 SHALL, when the counter reaches TIMEOUT without spi_done, return to IDLE, clear busy, and pulse timeout_err for one cycle.
REQ-023 SHALL give spi_done priority over timeout when both occur at the same edge: no timeout_err.
REQ-024 SHALL ignore spi_done in IDLE.
REQ-025 SHALL spend at least one cycle in IDLE between transfers: the minimum spi_start spacing is WAIT duration + 1 cycle.
REQ-026 SHALL size the counter to ceil(log2(TIMEOUT+1)) bits; the counter SHALL never wrap.

Reset
REQ-027 SHALL, while rst is high, asynchronously force the following state:
- FSM to IDLE; counter to 0.
- grant0, grant1, spi_start, busy and timeout_err to 0.
- spi_data and spi_dc to 0.
- Last-served pointer to requester 1, so requester 0 wins the first tie.
REQ-028 SHALL abandon any outstanding transfer on reset mid-WAIT, with no grant, spi_start or timeout_err pulse. After release, the first edge SHALL be treated as IDLE.
REQ-029 SHALL not drop spi_start or grant below one full cycle on reset release.

Verification
REQ-030 SHALL verify single request: req0=1, data0=8'hA5, dc0=0 from IDLE -> next cycle grant0=1, spi_start=1, spi_data=A5, spi_dc=0, busy=1. spi_done 3 cycles later -> busy=0 next cycle.
REQ-031 SHALL verify fairness: req0 and req1 held high continuously, spi_done returned each transfer -> grants alternate 0,1,0,1, with requester 0 first after reset.
REQ-032 SHALL verify timeout: TIMEOUT=4, req1=1, spi_done never asserted -> exactly one timeout_err pulse 4 cycles after spi_start; busy=0; next request is accepted.
REQ-033 SHALL verify a simultaneous event: spi_done on the same edge the counter hits TIMEOUT -> no timeout_err; busy=0.
REQ-034 SHALL verify reset mid-WAIT: rst pulsed during WAIT -> all outputs 0 immediately; a later tie goes to requester 0.
REQ-035 SHALL verify request drop: req1 pulsed only while busy, then released -> grant1 never asserted; a stray spi_done in IDLE causes no state change.
